// File: rtl/scr1_dmem_arbiter_pkg.sv
// Shared data-memory interface types used by the dmem router and the two-master arbiter.
package scr1_dmem_arbiter_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_VEC_WORDS   = 4;

    typedef logic [SCR1_VEC_WORDS-1:0][31:0] type_vector;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        ADDR = 1'b0,
        DATA = 1'b1
    } type_scr1_arb_fsm_e;

    function automatic logic [3:0] scr1_sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

endpackage

// File: rtl/scr1_dmem_arbiter_if.sv
// One scr1 dmem port: address phase req/req_ack, data phase resp/rdata.
interface scr1_dmem_if
    import scr1_dmem_arbiter_pkg::*;
#(
    parameter int AWIDTH = SCR1_DMEM_AWIDTH
) ();

    logic                 req;
    logic                 req_ack;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [AWIDTH-1:0]    addr;
    type_vector           wdata;
    type_vector           rdata;
    type_scr1_mem_resp_e  resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface

// File: rtl/scr1_dmem_arbiter_rr_arb2.sv
// Two-requester round-robin with a bounded burst; holds last grant owner and burst count.
module scr1_rr_arb2
    import scr1_dmem_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       issue_allowed,
    input  logic       grant,
    output logic       win
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    logic       last_r;
    logic [3:0] burst_cnt;
    logic       other_req;

    always_comb begin
        win = 1'b0;
        if (issue_allowed) begin
            if (&req) begin
                win = (burst_cnt < BURST_MAX) ? last_r : ~last_r;
            end else begin
                win = req[1];
            end
        end
    end

    assign other_req = win ? req[0] : req[1];

    // A lone requester restarts at 1 so it never exhausts its burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r    <= 1'b1;
            burst_cnt <= BURST_MAX;
        end else if (grant) begin
            last_r <= win;
            if (!other_req || (win != last_r)) begin
                burst_cnt <= 4'd1;
            end else begin
                burst_cnt <= scr1_sat_inc4(burst_cnt);
            end
        end
    end

endmodule

// File: rtl/scr1_dmem_arbiter.sv
// Shares the core dmem port between the LSU (m0) and the RLWE load/store engine (m1),
// tracking the owner of the single outstanding transaction to steer its response.
module scr1_dmem_arbiter
    import scr1_dmem_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int AWIDTH    = SCR1_DMEM_AWIDTH
) (
    input  logic     clk,
    input  logic     rst,
    scr1_dmem_if.slave  m0,
    scr1_dmem_if.slave  m1,
    scr1_dmem_if.master s
);

    type_scr1_arb_fsm_e   fsm;
    type_scr1_arb_fsm_e   fsm_next;
    logic                 owner_r;
    logic                 owner_next;
    logic                 issue_allowed;
    logic                 win;
    logic                 grant;
    logic                 resp_valid;
    logic                 win_req;
    type_scr1_mem_cmd_e   win_cmd;
    type_scr1_mem_width_e win_width;
    logic [AWIDTH-1:0]    win_addr;
    type_vector           win_wdata;

    // An RDY_ER cycle never issues; only RDY_OK lets a new request overlap completion.
    assign issue_allowed = !rst && ((fsm == ADDR) || (s.resp == SCR1_MEM_RESP_RDY_OK));
    assign resp_valid    = !rst && (fsm == DATA);

    scr1_rr_arb2 #(
        .BURST_LEN (BURST_LEN)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .req           ({m1.req, m0.req}),
        .issue_allowed (issue_allowed),
        .grant         (grant),
        .win           (win)
    );

    always_comb begin
        win_req   = win ? m1.req   : m0.req;
        win_cmd   = win ? m1.cmd   : m0.cmd;
        win_width = win ? m1.width : m0.width;
        win_addr  = win ? m1.addr  : m0.addr;
        win_wdata = win ? m1.wdata : m0.wdata;
    end

    assign s.req   = issue_allowed & win_req;
    assign s.cmd   = issue_allowed ? win_cmd : SCR1_MEM_CMD_ERROR;
    assign s.width = win_width;
    assign s.addr  = win_addr;
    assign s.wdata = win_wdata;
    assign grant   = s.req & s.req_ack;

    assign m0.req_ack = s.req_ack & issue_allowed & ~win & m0.req;
    assign m1.req_ack = s.req_ack & issue_allowed &  win & m1.req;

    assign m0.resp  = (resp_valid && !owner_r) ? s.resp  : SCR1_MEM_RESP_NOTRDY;
    assign m0.rdata = (resp_valid && !owner_r) ? s.rdata : '0;
    assign m1.resp  = (resp_valid &&  owner_r) ? s.resp  : SCR1_MEM_RESP_NOTRDY;
    assign m1.rdata = (resp_valid &&  owner_r) ? s.rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= ADDR;
            owner_r <= 1'b0;
        end else begin
            fsm     <= fsm_next;
            owner_r <= owner_next;
        end
    end

    always_comb begin
        fsm_next   = fsm;
        owner_next = grant ? win : owner_r;
        case (fsm)
            ADDR: begin
                if (grant) fsm_next = DATA;
            end
            DATA: begin
                case (s.resp)
                    SCR1_MEM_RESP_RDY_OK: fsm_next = grant ? DATA : ADDR;
                    SCR1_MEM_RESP_RDY_ER: fsm_next = ADDR;
                    default:              fsm_next = DATA;
                endcase
            end
            default: fsm_next = ADDR;
        endcase
    end

endmodule

// File: tb/tb_scr1_dmem_arbiter.sv
// Directed bench for scr1_dmem_arbiter: reset, single master, contention, pipelining, errors, waits.
module tb_scr1_dmem_arbiter;
    import scr1_dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    scr1_dmem_if #(.AWIDTH(32)) m0_bus ();
    scr1_dmem_if #(.AWIDTH(32)) m1_bus ();
    scr1_dmem_if #(.AWIDTH(32)) s_bus ();

    scr1_dmem_arbiter #(
        .BURST_LEN (4),
        .AWIDTH    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    task automatic idle_inputs();
        m0_bus.req    = 1'b0;
        m0_bus.cmd    = SCR1_MEM_CMD_RD;
        m0_bus.width  = SCR1_MEM_WIDTH_WORD;
        m0_bus.addr   = 32'h0001_0000;
        m0_bus.wdata  = '0;
        m1_bus.req    = 1'b0;
        m1_bus.cmd    = SCR1_MEM_CMD_WR;
        m1_bus.width  = SCR1_MEM_WIDTH_WORD;
        m1_bus.addr   = 32'h0002_0000;
        m1_bus.wdata  = '0;
        m1_bus.wdata[0] = 32'hCAFE_0001;
        s_bus.req_ack = 1'b0;
        s_bus.resp    = SCR1_MEM_RESP_NOTRDY;
        s_bus.rdata   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m0_bus.req    = 1'b1;
        m1_bus.req    = 1'b1;
        s_bus.req_ack = 1'b1;
        s_bus.resp    = SCR1_MEM_RESP_RDY_OK;
        s_bus.rdata[0] = 32'h1111_2222;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (s_bus.req !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_s_req: got %0b expected 0", s_bus.req);
        end
        checks++;
        if (m0_bus.req_ack !== 1'b0 || m1_bus.req_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_acks: got m0=%0b m1=%0b expected 0 0", m0_bus.req_ack, m1_bus.req_ack);
        end
        checks++;
        if (m0_bus.resp !== SCR1_MEM_RESP_NOTRDY || m1_bus.resp !== SCR1_MEM_RESP_NOTRDY) begin
            errors++; $display("[TB] FAIL reset_resp: got m0=%0d m1=%0d expected NOTRDY", m0_bus.resp, m1_bus.resp);
        end
        checks++;
        if (m0_bus.rdata !== '0 || m1_bus.rdata !== '0) begin
            errors++; $display("[TB] FAIL reset_rdata: got m0=%h m1=%h expected 0", m0_bus.rdata, m1_bus.rdata);
        end
        checks++;
        if (dut.fsm !== ADDR || dut.owner_r !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_state: got fsm=%0d owner=%0b expected ADDR 0", dut.fsm, dut.owner_r);
        end
        checks++;
        if (dut.u_arb.last_r !== 1'b1 || dut.u_arb.burst_cnt !== 4'd4) begin
            errors++; $display("[TB] FAIL reset_arb: got last=%0b cnt=%0d expected 1 4", dut.u_arb.last_r, dut.u_arb.burst_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_master();
        @(negedge clk);
        m0_bus.req    = 1'b1;
        s_bus.req_ack = 1'b1;
        #1;
        checks++;
        if (s_bus.req !== 1'b1 || s_bus.addr !== 32'h0001_0000 || s_bus.cmd !== SCR1_MEM_CMD_RD) begin
            errors++; $display("[TB] FAIL single_fwd: got req=%0b addr=%h cmd=%0d expected 1 00010000 RD", s_bus.req, s_bus.addr, s_bus.cmd);
        end
        checks++;
        if (m0_bus.req_ack !== 1'b1 || m1_bus.req_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL single_ack: got m0=%0b m1=%0b expected 1 0", m0_bus.req_ack, m1_bus.req_ack);
        end
        @(negedge clk);
        m0_bus.req     = 1'b0;
        s_bus.req_ack  = 1'b0;
        s_bus.resp     = SCR1_MEM_RESP_RDY_OK;
        s_bus.rdata[0] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m0_bus.resp !== SCR1_MEM_RESP_RDY_OK || m0_bus.rdata[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL single_resp: got resp=%0d rdata=%h expected RDY_OK deadbeef", m0_bus.resp, m0_bus.rdata[0]);
        end
        checks++;
        if (m1_bus.resp !== SCR1_MEM_RESP_NOTRDY || m1_bus.rdata !== '0) begin
            errors++; $display("[TB] FAIL single_nonowner: got resp=%0d rdata=%h expected NOTRDY 0", m1_bus.resp, m1_bus.rdata);
        end
        @(negedge clk);
        s_bus.resp  = SCR1_MEM_RESP_NOTRDY;
        s_bus.rdata = '0;
        #1;
        checks++;
        if (dut.fsm !== ADDR || m0_bus.resp !== SCR1_MEM_RESP_NOTRDY) begin
            errors++; $display("[TB] FAIL single_done: got fsm=%0d resp=%0d expected ADDR NOTRDY", dut.fsm, m0_bus.resp);
        end
    endtask

    task automatic test_contention();
        logic [8:0]  exp_win;
        logic        prev;
        logic        w;
        logic [31:0] exp_addr;
        exp_win = 9'b0_1111_0000;
        prev    = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            m0_bus.req    = 1'b1;
            m1_bus.req    = 1'b1;
            s_bus.req_ack = 1'b1;
            s_bus.resp    = SCR1_MEM_RESP_RDY_OK;
            #1;
            w        = exp_win[i];
            exp_addr = w ? 32'h0002_0000 : 32'h0001_0000;
            checks++;
            if (m0_bus.req_ack !== ~w || m1_bus.req_ack !== w || s_bus.addr !== exp_addr) begin
                errors++; $display("[TB] FAIL contention_grant%0d: got m0=%0b m1=%0b addr=%h expected winner m%0d addr=%h",
                                   i, m0_bus.req_ack, m1_bus.req_ack, s_bus.addr, w, exp_addr);
            end
            if (i > 0) begin
                checks++;
                if ((prev ? m1_bus.resp : m0_bus.resp) !== SCR1_MEM_RESP_RDY_OK ||
                    (prev ? m0_bus.resp : m1_bus.resp) !== SCR1_MEM_RESP_NOTRDY) begin
                    errors++; $display("[TB] FAIL contention_steer%0d: got m0=%0d m1=%0d expected RDY_OK to m%0d",
                                       i, m0_bus.resp, m1_bus.resp, prev);
                end
            end
            prev = w;
        end
        @(negedge clk);
        m0_bus.req    = 1'b0;
        m1_bus.req    = 1'b0;
        s_bus.req_ack = 1'b0;
        @(negedge clk);
        s_bus.resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic test_pipelined_switch();
        do_reset();
        @(negedge clk);
        m0_bus.req    = 1'b1;
        s_bus.req_ack = 1'b1;
        #1;
        checks++;
        if (m0_bus.req_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL pipe_first_ack: got %0b expected 1", m0_bus.req_ack);
        end
        @(negedge clk);
        m0_bus.req = 1'b0;
        m1_bus.req = 1'b1;
        s_bus.resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        checks++;
        if (m0_bus.resp !== SCR1_MEM_RESP_RDY_OK || m1_bus.req_ack !== 1'b1 || m0_bus.req_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL pipe_switch: got m0_resp=%0d m1_ack=%0b m0_ack=%0b expected RDY_OK 1 0",
                               m0_bus.resp, m1_bus.req_ack, m0_bus.req_ack);
        end
        @(negedge clk);
        m1_bus.req = 1'b0;
        s_bus.resp = SCR1_MEM_RESP_NOTRDY;
        #1;
        checks++;
        if (dut.owner_r !== 1'b1 || dut.fsm !== DATA) begin
            errors++; $display("[TB] FAIL pipe_owner: got owner=%0b fsm=%0d expected 1 DATA", dut.owner_r, dut.fsm);
        end
        @(negedge clk);
        s_bus.resp = SCR1_MEM_RESP_RDY_OK;
        #1;
        checks++;
        if (m1_bus.resp !== SCR1_MEM_RESP_RDY_OK || m0_bus.resp !== SCR1_MEM_RESP_NOTRDY) begin
            errors++; $display("[TB] FAIL pipe_m1_resp: got m1=%0d m0=%0d expected RDY_OK NOTRDY", m1_bus.resp, m0_bus.resp);
        end
        @(negedge clk);
        s_bus.resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic test_error();
        @(negedge clk);
        m1_bus.req    = 1'b1;
        s_bus.req_ack = 1'b1;
        #1;
        checks++;
        if (m1_bus.req_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL err_m1_ack: got %0b expected 1", m1_bus.req_ack);
        end
        @(negedge clk);
        m1_bus.req = 1'b0;
        m0_bus.req = 1'b1;
        s_bus.resp = SCR1_MEM_RESP_RDY_ER;
        #1;
        checks++;
        if (m1_bus.resp !== SCR1_MEM_RESP_RDY_ER || m0_bus.resp !== SCR1_MEM_RESP_NOTRDY) begin
            errors++; $display("[TB] FAIL err_resp: got m1=%0d m0=%0d expected RDY_ER NOTRDY", m1_bus.resp, m0_bus.resp);
        end
        checks++;
        if (m0_bus.req_ack !== 1'b0 || s_bus.req !== 1'b0 || s_bus.cmd !== SCR1_MEM_CMD_ERROR) begin
            errors++; $display("[TB] FAIL err_no_issue: got m0_ack=%0b s_req=%0b cmd=%0d expected 0 0 ERROR",
                               m0_bus.req_ack, s_bus.req, s_bus.cmd);
        end
        @(negedge clk);
        s_bus.resp = SCR1_MEM_RESP_NOTRDY;
        #1;
        checks++;
        if (dut.fsm !== ADDR || m0_bus.req_ack !== 1'b1) begin
            errors++; $display("[TB] FAIL err_regrant: got fsm=%0d m0_ack=%0b expected ADDR 1", dut.fsm, m0_bus.req_ack);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.fsm !== DATA || dut.owner_r !== 1'b0) begin
            errors++; $display("[TB] FAIL err_owner: got fsm=%0d owner=%0b expected DATA 0", dut.fsm, dut.owner_r);
        end
    endtask

    task automatic test_wait_states();
        m0_bus.req    = 1'b1;
        m1_bus.req    = 1'b1;
        s_bus.req_ack = 1'b1;
        s_bus.resp    = SCR1_MEM_RESP_NOTRDY;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (dut.fsm !== DATA || s_bus.req !== 1'b0 || m0_bus.req_ack !== 1'b0 ||
                m1_bus.req_ack !== 1'b0 || dut.owner_r !== 1'b0) begin
                errors++; $display("[TB] FAIL wait%0d: got fsm=%0d s_req=%0b acks=%0b%0b owner=%0b expected DATA 0 00 0",
                                   i, dut.fsm, s_bus.req, m1_bus.req_ack, m0_bus.req_ack, dut.owner_r);
            end
        end
        @(negedge clk);
        m0_bus.req    = 1'b0;
        m1_bus.req    = 1'b0;
        s_bus.req_ack = 1'b0;
        s_bus.resp    = SCR1_MEM_RESP_RDY_OK;
        @(negedge clk);
        s_bus.resp = SCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m1_bus.req    = 1'b1;
        s_bus.req_ack = 1'b1;
        @(negedge clk);
        m1_bus.req    = 1'b0;
        s_bus.req_ack = 1'b0;
        #1;
        checks++;
        if (dut.fsm !== DATA || dut.owner_r !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_pre: got fsm=%0d owner=%0b expected DATA 1", dut.fsm, dut.owner_r);
        end
        #1;
        rst            = 1'b1;
        m0_bus.req     = 1'b1;
        s_bus.req_ack  = 1'b1;
        s_bus.resp     = SCR1_MEM_RESP_RDY_OK;
        s_bus.rdata[0] = 32'h1234_5678;
        #1;
        checks++;
        if (m1_bus.resp !== SCR1_MEM_RESP_NOTRDY || m1_bus.rdata !== '0 || s_bus.req !== 1'b0 ||
            m0_bus.req_ack !== 1'b0 || dut.fsm !== ADDR) begin
            errors++; $display("[TB] FAIL rstmid_async: got m1_resp=%0d m1_rdata=%h s_req=%0b m0_ack=%0b fsm=%0d expected NOTRDY 0 0 0 ADDR",
                               m1_bus.resp, m1_bus.rdata, s_bus.req, m0_bus.req_ack, dut.fsm);
        end
        @(negedge clk);
        rst         = 1'b0;
        s_bus.resp  = SCR1_MEM_RESP_NOTRDY;
        s_bus.rdata = '0;
        m1_bus.req  = 1'b1;
        #1;
        checks++;
        if (dut.fsm !== ADDR || m0_bus.req_ack !== 1'b1 || m1_bus.req_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_regrant: got fsm=%0d m0_ack=%0b m1_ack=%0b expected ADDR 1 0",
                               dut.fsm, m0_bus.req_ack, m1_bus.req_ack);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_contention();
        test_pipelined_switch();
        test_error();
        test_wait_states();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_arbiter.md
# scr1_dmem_arbiter

Two-master arbiter that shares the single core data-memory interface feeding `scr1_dmem_router` between master 0, the core LSU, and master 1, the RLWE vector accelerator's load/store engine. Requests use the scr1 dmem protocol: an address phase with `req`/`req_ack`, followed by a data phase carrying `resp` and `rdata`. The block picks a winner with a round-robin policy and a bounded burst length. It tracks the owner of the single outstanding transaction, steers the response back to that owner only, and supports back-to-back pipelined issue exactly as the downstream router does.

## Interface
Parameters:
- `BURST_LEN`, default 4: maximum consecutive grants to one master while the other master has `req` asserted. Range 1..15.
- `AWIDTH`, default `` `SCR1_DMEM_AWIDTH ``: address width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `m0_req`, `m1_req`  in  1  address-phase request.
- `m0_req_ack`, `m1_req_ack`  out  1  address phase accepted this cycle.
- `m0_cmd`, `m1_cmd`  in  `type_scr1_mem_cmd_e`  command.
- `m0_width`, `m1_width`  in  `type_scr1_mem_width_e`  access width.
- `m0_addr`, `m1_addr`  in  AWIDTH  address.
- `m0_wdata`, `m1_wdata`  in  `type_vector`  write data.
- `m0_rdata`, `m1_rdata`  out  `type_vector`  read data.
- `m0_resp`, `m1_resp`  out  `type_scr1_mem_resp_e`  response.
- `s_req`  out  1  request to the router.
- `s_req_ack`  in  1  router accepted the request.
- `s_cmd`, `s_width`, `s_addr`, `s_wdata`  out  command, width, address and write data to the router; same types as the master side.
- `s_rdata`  in  `type_vector`  read data from the router.
- `s_resp`  in  `type_scr1_mem_resp_e`  response from the router.

## Operation
State machine (`fsm`):
- **ADDR**: no transaction is outstanding.
- **DATA**: one transaction is outstanding; `owner_r` holds the master that issued it.

Arbitration (`win`) is evaluated whenever issue is allowed. Issue is allowed in ADDR, or in DATA in a cycle where `s_resp == RDY_OK`.
- Only one master requesting: that master wins.
- Both masters requesting: `last_r` is the master of the previous grant.
  - If `burst_cnt < BURST_LEN`, the `last_r` master keeps the grant.
  - Otherwise the other master wins.
- Reset state: `last_r = 1` and `burst_cnt = BURST_LEN`, so master 0 wins the first contention.

Forwarding (purely combinational, no added latency):
- `s_req`, `s_cmd`, `s_width`, `s_addr` and `s_wdata` come from `win`, and only while issue is allowed.
- When issue is not allowed: `s_req = 0` and `s_cmd = SCR1_MEM_CMD_ERROR`.
- `mX_req_ack = s_req_ack & issue_allowed & (win == X) & mX_req`.

On a grant (`s_req & s_req_ack`):
- `fsm` goes to DATA and `owner_r` takes `win`.
- If `win == last_r`, `burst_cnt` increments, saturating at 15. Otherwise `burst_cnt` is set to 1 and `last_r` takes `win`.
- If the non-winning master is not requesting, `burst_cnt` is set to 1. A lone requester therefore never exhausts its burst.

Data phase:
- The owner's `mX_rdata = s_rdata` and `mX_resp = s_resp`.
- The non-owner sees `resp = SCR1_MEM_RESP_NOTRDY` and `rdata = '0`.
- In ADDR, both masters see NOTRDY and `'0`.

DATA-state transitions:
- `s_resp == RDY_OK` with a new grant in the same cycle: stay in DATA; `owner_r` is updated.
- `s_resp == RDY_OK` with no new grant: go to ADDR.
- `s_resp == RDY_ER`: go to ADDR. No issue is allowed in that cycle, matching the router's error rule.
- `s_resp == NOTRDY`: hold state.

## Timing
- Reset values: `fsm = ADDR`, `owner_r = 0`, `last_r = 1`, `burst_cnt = BURST_LEN`.
- While `rst` is high, all outputs are forced inactive: `s_req = 0`, both `mX_req_ack = 0`, both `mX_resp = NOTRDY`, and all rdata `'0`.
- Address path: zero cycles from `mX_req` to `s_req`. Data path: zero cycles from `s_resp` to `mX_resp`.
- Minimum issue interval: one request per cycle when the router returns RDY_OK in the cycle after each grant.
- Simultaneous completion and new grant: the response goes to the old `owner_r`, and the ack goes to the new `win` in the same cycle.
- Reset asserted mid-transaction: the transaction is dropped. The masters observe NOTRDY and must reissue.
- A master that drops `req` before its ack is legal. Arbitration simply re-evaluates in the next cycle.

## Structure
- The `type_scr1_mem_*` enums and `type_vector` come from the existing shared memif/defines package.
- The local FSM enum `type_scr1_arb_fsm_e` (values ADDR, DATA) is added to that package so the router and arbiter share the encoding.
- One natural sub-module: `scr1_rr_arb2`. It holds `last_r` and `burst_cnt` and produces `win` from `{m1_req, m0_req}`, `issue_allowed` and `grant`. The top level holds `fsm`, `owner_r` and the muxes.

## Test plan
- **Single master.** `m0` issues a read to `0x00010000`, router acks, then returns RDY_OK with `rdata[0] = 0xDEADBEEF` one cycle later → `m0_resp = RDY_OK`, `m0_rdata[0] = 0xDEADBEEF`; `m1_resp = NOTRDY` throughout.
- **Contention after reset, `BURST_LEN = 4`.** Both masters hold `req` continuously with immediate ack and RDY_OK → grant order m0, m0, m0, m0, m1, m1, m1, m1, m0.
- **Pipelined owner switch.** `m0` is in DATA when `s_resp = RDY_OK` arrives and only `m1` is requesting → in that same cycle `m0_resp = RDY_OK` and `m1_req_ack = 1`; `owner_r = 1` on the next cycle.
- **Error response.** Owner `m1` receives `s_resp = RDY_ER` while `m0_req = 1` → `m1_resp = RDY_ER`, `m0_req_ack = 0` that cycle; `m0` is granted in the following cycle from ADDR.
- **Wait states.** Router returns NOTRDY for 5 cycles → `fsm` stays in DATA, `s_req = 0`, both acks are 0, and `owner_r` is stable.
- **Reset mid-transaction.** Assert `rst` during DATA → outputs go inactive asynchronously; after release, `fsm = ADDR` and the next contention is granted to `m0`.
